seq_mult_unit: RTL and testbench

Self-contained, parametrised shift-add sequential multiplier that combines control and datapath in one module. It is the successor to the fixed-width multiplier controller with separate datapath. It adds signed/unsigned mode per operation, early termination once the remaining multiplier bits are zero, a start/in_ready input handshake, and a product_valid/product_ready output handshake with backpressure. It sits between an operand producer and a result consumer in the arithmetic pipeline.

---
 rtl/seq_mult_unit.sv | 119 +++++++++++
 tb/tb_seq_mult_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seq_mult_unit.sv
// Shift-add sequential multiplier with signed/unsigned mode, optional early termination,
// and valid/ready handshakes on both the operand and the product side.
//
// state | meaning
// IDLE  | waiting for start; in_ready high
// RUN   | one shift-add iteration per cycle
// FIX   | apply sign to accumulator, latch product and run_cycles
// DONE  | product_valid high until product_ready
module seq_mult_unit #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         signed_mode,
  input  logic [WIDTH-1:0]             multiplicand,
  input  logic [WIDTH-1:0]             multiplier,
  output logic                         in_ready,
  output logic                         busy,
  output logic [2*WIDTH-1:0]           product,
  output logic                         product_valid,
  input  logic                         product_ready,
  output logic [$clog2(WIDTH+1)-1:0]   run_cycles
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   md_q, md_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   product_q, product_d;
  logic [CW-1:0]   run_cycles_q, run_cycles_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] mr_next;
  logic [CW-1:0]    cnt_next;

  // Negating -2^(WIDTH-1) wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign mag_a    = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign mag_b    = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
  assign mr_next  = mr_q >> 1;
  assign cnt_next = cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    md_d         = md_q;
    mr_d         = mr_q;
    cnt_d        = cnt_q;
    neg_d        = neg_q;
    product_d    = product_q;
    run_cycles_d = run_cycles_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          md_d    = {{WIDTH{1'b0}}, mag_a};
          mr_d    = mag_b;
          cnt_d   = '0;
          neg_d   = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          state_d = (EARLY_TERM && (mag_b == '0)) ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (mr_q[0]) acc_d = acc_q + md_q;
        md_d  = md_q << 1;
        mr_d  = mr_next;
        cnt_d = cnt_next;
        if (EARLY_TERM ? (mr_next == '0) : (cnt_next == CW'(WIDTH)))
          state_d = S_FIX;
      end
      S_FIX: begin
        product_d    = neg_q ? -acc_q : acc_q;
        run_cycles_d = cnt_q;
        state_d      = S_DONE;
      end
      S_DONE: begin
        if (product_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      md_q         <= '0;
      mr_q         <= '0;
      cnt_q        <= '0;
      neg_q        <= 1'b0;
      product_q    <= '0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      md_q         <= md_d;
      mr_q         <= mr_d;
      cnt_q        <= cnt_d;
      neg_q        <= neg_d;
      product_q    <= product_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign product_valid = (state_q == S_DONE);
  assign product       = product_q;
  assign run_cycles    = run_cycles_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit: one early-terminating and one full-iteration instance,
// hand-computed products, latencies and handshake behaviour.
module tb_seq_mult_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       product_ready = 1'b0;
  logic       start_s [2];

  wire [15:0] prod_w  [2];
  wire        valid_w [2];
  wire        rdy_w   [2];
  wire        busy_w  [2];
  wire [3:0]  cyc_w   [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_mult_unit #(.WIDTH(8), .EARLY_TERM(1'b1)) dut_et (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .signed_mode(signed_mode),
    .multiplicand(op_a), .multiplier(op_b), .in_ready(rdy_w[0]), .busy(busy_w[0]),
    .product(prod_w[0]), .product_valid(valid_w[0]), .product_ready(product_ready),
    .run_cycles(cyc_w[0])
  );

  seq_mult_unit #(.WIDTH(8), .EARLY_TERM(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .signed_mode(signed_mode),
    .multiplicand(op_a), .multiplier(op_b), .in_ready(rdy_w[1]), .busy(busy_w[1]),
    .product(prod_w[1]), .product_valid(valid_w[1]), .product_ready(product_ready),
    .run_cycles(cyc_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Edges are counted including the accept edge.
  task automatic run_op(input int u, input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p, input logic [3:0] exp_c, input int exp_edges,
                        input int hold, input logic ready_early);
    int edges;
    logic [15:0] held;
    @(negedge clk);
    check($sformatf("%s in_ready before", tag_of(u, a, b)), 32'(rdy_w[u]), 32'd1);
    signed_mode   = sm;
    op_a          = a;
    op_b          = b;
    start_s[u]    = 1'b1;
    product_ready = ready_early;
    @(posedge clk);
    edges = 1;
    #1;
    start_s[u] = 1'b0;
    op_a = ~a;
    op_b = ~b;
    signed_mode = ~sm;
    while (!valid_w[u] && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
    end
    check($sformatf("%s latency", tag_of(u, a, b)), 32'(edges), 32'(exp_edges));
    check($sformatf("%s product", tag_of(u, a, b)), 32'(prod_w[u]), 32'(exp_p));
    check($sformatf("%s run_cycles", tag_of(u, a, b)), 32'(cyc_w[u]), 32'(exp_c));
    check($sformatf("%s busy in done", tag_of(u, a, b)), 32'(busy_w[u]), 32'd1);
    held = prod_w[u];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start_s[u] = 1'b1;
      op_a = 8'h01;
      op_b = 8'h01;
      @(posedge clk);
      #1;
      check($sformatf("bp valid %0d", i), 32'(valid_w[u]), 32'd1);
      check($sformatf("bp in_ready %0d", i), 32'(rdy_w[u]), 32'd0);
      check($sformatf("bp product %0d", i), 32'(prod_w[u]), 32'(held));
    end
    @(negedge clk);
    start_s[u] = 1'b0;
    product_ready = 1'b1;
    @(posedge clk);
    #1;
    check($sformatf("%s idle after ready", tag_of(u, a, b)), 32'(rdy_w[u]), 32'd1);
    check($sformatf("%s valid drop", tag_of(u, a, b)), 32'(valid_w[u]), 32'd0);
    check($sformatf("%s product retained", tag_of(u, a, b)), 32'(prod_w[u]), 32'(exp_p));
    @(negedge clk);
    product_ready = 1'b0;
  endtask

  function automatic string tag_of(input int u, input logic [7:0] a, input logic [7:0] b);
    return $sformatf("u%0d %0h*%0h", u, a, b);
  endfunction

  initial begin
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    #12;
    check("rst product", 32'(prod_w[0]), 32'd0);
    check("rst valid", 32'(valid_w[0]), 32'd0);
    check("rst run_cycles", 32'(cyc_w[0]), 32'd0);
    check("rst in_ready", 32'(rdy_w[0]), 32'd1);
    check("rst busy", 32'(busy_w[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 1'b0, 8'd13,  8'd11,  16'h008F, 4'd4, 6,  0, 1'b0);
    run_op(0, 1'b0, 8'd13,  8'd0,   16'h0000, 4'd0, 2,  0, 1'b0);
    run_op(0, 1'b0, 8'd255, 8'd255, 16'hFE01, 4'd8, 10, 0, 1'b1);
    run_op(0, 1'b1, 8'hFD,  8'd5,   16'hFFF1, 4'd3, 5,  0, 1'b0);
    run_op(0, 1'b1, 8'h80,  8'h80,  16'h4000, 4'd8, 10, 0, 1'b1);
    run_op(0, 1'b1, 8'h80,  8'h7F,  16'hC080, 4'd7, 9,  0, 1'b0);
    run_op(0, 1'b1, 8'h00,  8'hF6,  16'h0000, 4'd4, 6,  0, 1'b0);
    run_op(0, 1'b0, 8'd9,   8'd3,   16'd27,   4'd2, 4,  5, 1'b0);
    run_op(1, 1'b0, 8'd13,  8'd11,  16'h008F, 4'd8, 10, 0, 1'b0);
    run_op(1, 1'b1, 8'hFD,  8'd5,   16'hFFF1, 4'd8, 10, 0, 1'b1);

    // Abort mid-RUN with a nonzero product still held from earlier ops.
    @(negedge clk);
    signed_mode = 1'b0;
    op_a = 8'd255;
    op_b = 8'd255;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid busy", 32'(busy_w[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort in_ready", 32'(rdy_w[0]), 32'd1);
    check("abort product", 32'(prod_w[0]), 32'd0);
    check("abort valid", 32'(valid_w[0]), 32'd0);
    check("abort run_cycles", 32'(cyc_w[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b0, 8'd7, 8'd6, 16'd42, 4'd3, 5, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
